// File: rtl/nss_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM states
// and the counter width helper.
package nss_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nss_state_t;

  // Counter must hold 0..N-1; a single-nibble operand still needs one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / NIB);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_bla4.sv
// 4-bit borrow-lookahead subtract slice: {bo, d} = x - y - bi.
module bla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] b;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Every borrow is a flat sum of products of g/p/bi, so no ripple path.
  assign b[0] = bi;
  assign b[1] = g[0] | (p[0] & bi);
  assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bi);
  assign b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d  = x ^ y ^ b[3:0];
  assign bo = b[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle unsigned subtractor diff = a - b - bin, one nibble per clock,
// LSB nibble first, with a load/busy/done handshake.
module nibble_serial_sub
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / NIB;
  localparam int CW = cnt_width(WIDTH);

  if (((WIDTH % NIB) != 0) || (WIDTH < NIB)) begin : g_width_check
    $error("nibble_serial_sub: WIDTH must be a positive multiple of 4");
  end

  nss_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic             breg_q, breg_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [NIB-1:0]   slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] wr_shift;

  bla4 u_slice (
    .x  (wa_q[NIB-1:0]),
    .y  (wb_q[NIB-1:0]),
    .bi (breg_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // New nibble enters at the top so that after N shifts the LSB nibble sits at bit 0.
  if (N == 1) begin : g_wr_one
    assign wr_shift = slice_d;
  end else begin : g_wr_many
    assign wr_shift = {slice_d, wr_q[WIDTH-1:NIB]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wr_d    = wr_q;
    breg_d  = breg_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (load) begin
          wa_d    = a;
          wb_d    = b;
          breg_d  = bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        wa_d   = wa_q >> NIB;
        wb_d   = wb_q >> NIB;
        wr_d   = wr_shift;
        breg_d = slice_bo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = wr_shift;
          bout_d  = slice_bo;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      wr_q    <= '0;
      breg_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      wr_q    <= wr_d;
      breg_q  <= breg_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=16 plus a WIDTH=4 instance).
module tb_nibble_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done;
  logic [15:0] diff;
  logic        bout;

  logic        load4;
  logic [3:0]  a4, b4;
  logic        bin4;
  logic        busy4, done4;
  logic [3:0]  diff4;
  logic        bout4;

  logic [16:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_sub #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  nibble_serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load(load4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load cycle and push the reference {bout, diff} to the scoreboard.
  task automatic start_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci);
    logic [16:0] r;
    a = ai; b = bi; bin = ci; load = 1'b1;
    r = {1'b0, ai} - {1'b0, bi} - {16'd0, ci};
    exp_q.push_back(r);
    tick();
    load = 1'b0;
    a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
  endtask

  // Returns cycles from the accepting edge to done and cycles busy was seen.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; load4 = 1'b0;
    a = '0; b = '0; bin = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({bout, diff} !== 17'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", {bout, diff}); end
    total++; if ({busy4, done4, bout4, diff4} !== 7'd0) begin bad++; $display("FAIL reset_w4 got=%h exp=0", {busy4, done4, bout4, diff4}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc; bit ok; logic [16:0] e;
    start_op(16'h1234, 16'h0234, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    wait_done(lat, bc, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    e = exp_q.pop_front();
    total++; if ({bout, diff} !== e) begin bad++; $display("FAIL basic_result got=%h exp=%h", {bout, diff}, e); end
    tick();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b exp=00", {busy, done}); end
    total++; if ({bout, diff} !== e) begin bad++; $display("FAIL basic_hold got=%h exp=%h", {bout, diff}, e); end
  endtask

  task automatic test_borrow_ripple();
    int lat, bc; bit ok; logic [16:0] e;
    start_op(16'h1000, 16'h0001, 1'b0);
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || {bout, diff} !== e) begin bad++; $display("FAIL ripple_result got=%h exp=%h", {bout, diff}, e); end
    tick();
  endtask

  task automatic test_underflow();
    int lat, bc; bit ok; logic [16:0] e;
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || {bout, diff} !== e) begin bad++; $display("FAIL underflow_result got=%h exp=%h", {bout, diff}, e); end
    tick();
    start_op(16'h8000, 16'h0000, 1'b1);
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || {bout, diff} !== e) begin bad++; $display("FAIL bin_result got=%h exp=%h", {bout, diff}, e); end
    tick();
    start_op(16'hA5A5, 16'hA5A5, 1'b1);
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || {bout, diff} !== e) begin bad++; $display("FAIL equal_bin_result got=%h exp=%h", {bout, diff}, e); end
    tick();
  endtask

  task automatic test_load_ignored();
    int lat, bc; bit ok; logic [16:0] e, prev;
    prev = {bout, diff};
    start_op(16'h5555, 16'h1111, 1'b0);
    tick();
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; load = 1'b1;
    total++; if ({bout, diff} !== prev) begin bad++; $display("FAIL run_hold got=%h exp=%h", {bout, diff}, prev); end
    tick();
    load = 1'b0;
    wait_done(lat, bc, ok);
    total++; if (lat !== 2) begin bad++; $display("FAIL ignore_latency got=%0d exp=2", lat); end
    e = exp_q.pop_front();
    total++; if (!ok || {bout, diff} !== e) begin bad++; $display("FAIL ignore_result got=%h exp=%h", {bout, diff}, e); end
    tick(); tick();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ignore_no_extra got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_reset_midop();
    int lat, bc, pulses; bit ok; logic [16:0] e;
    start_op(16'h9876, 16'h1234, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_state got=%b exp=00", {busy, done}); end
    total++; if ({bout, diff} !== 17'd0) begin bad++; $display("FAIL midrst_out got=%h exp=0", {bout, diff}); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_done_pulses got=%0d exp=0", pulses); end
    start_op(16'h0F0F, 16'h00FF, 1'b1);
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || lat !== 4 || {bout, diff} !== e) begin bad++; $display("FAIL midrst_next got=%h lat=%0d exp=%h lat=4", {bout, diff}, lat, e); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit ok; logic [16:0] e;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_in_done got=%b exp=1", done); end
    start_op(16'h0003, 16'h0005, 1'b0);
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_no_gap got=%b exp=10", {busy, done}); end
    wait_done(lat, bc, ok);
    e = exp_q.pop_front();
    total++; if (!ok || lat !== 4 || {bout, diff} !== e) begin bad++; $display("FAIL b2b_result got=%h lat=%0d exp=%h lat=4", {bout, diff}, lat, e); end
    tick();
  endtask

  task automatic test_width4();
    logic [4:0] e4;
    a4 = 4'd3; b4 = 4'd5; bin4 = 1'b0; load4 = 1'b1;
    e4 = {1'b0, 4'd3} - {1'b0, 4'd5};
    tick();
    load4 = 1'b0;
    total++; if ({busy4, done4} !== 2'b10) begin bad++; $display("FAIL w4_busy got=%b exp=10", {busy4, done4}); end
    tick();
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL w4_latency got=%b exp=1", done4); end
    total++; if ({bout4, diff4} !== e4) begin bad++; $display("FAIL w4_result got=%h exp=%h", {bout4, diff4}, e4); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_underflow();
    test_load_ignored();
    test_reset_midop();
    test_back_to_back();
    test_width4();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
